// File: rtl/life_pkg.sv
// life_pkg
// Shared definitions for the Game-of-Life pipeline: default grid geometry
// and the generation scheduler state encoding.
package life_pkg;

    localparam int ROWS  = 720;   // grid rows per generation
    localparam int COLS  = 1280;  // grid columns (cells per row)
    localparam int ROW_W = 10;    // row index width

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        RUN,
        DRAIN,
        SWAP
    } sched_state_t;

endpackage : life_pkg

// File: rtl/life_gen_scheduler.sv
// life_gen_scheduler
// Sequences one Game-of-Life generation at a time. Primes row 0 into the
// line buffer for three cycles, streams rows 1..ROWS-1 one per cycle,
// waits for the next-state writeback to drain, then swaps the front/back
// BRAM banks.
//
// Ports:
//   clk          single clock, all logic on posedge
//   rst_n        asynchronous active-low reset
//   run          level: free-running generations while high
//   step         one-cycle pulse: one generation when idle
//   disp_vblank  display vertical blank (bank swap window)
//   lb_valid     line buffer valid_set
//   calc_row     row index to the line buffer
//   calc_flag    row is to be computed and written back
//   front_bank   bank read by compute and display; writes go to ~front_bank
//   busy         high in any state except IDLE
//   gen_done     one-cycle pulse on bank swap
//   gen_count    completed generations (wraps)
//   seq_err      sticky: lb_valid seen low while streaming rows
//
// Build option LIFE_SCHED_VBLANK_SYNC_EN: when defined, the bank swap is
// held until disp_vblank is high so the display never sees a mid-frame
// bank change. When undefined, disp_vblank is ignored.
module life_gen_scheduler #(
    parameter int ROWS         = life_pkg::ROWS,
    parameter int ROW_W        = life_pkg::ROW_W,
    parameter int DRAIN_CYCLES = 2,
    parameter int GEN_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             step,
    input  logic             disp_vblank,
    input  logic             lb_valid,
    output logic [ROW_W-1:0] calc_row,
    output logic             calc_flag,
    output logic             front_bank,
    output logic             busy,
    output logic             gen_done,
    output logic [GEN_W-1:0] gen_count,
    output logic             seq_err
);
    import life_pkg::*;

    // One counter serves both the 3-cycle prime and the drain wait.
    localparam int CNT_W = (DRAIN_CYCLES > 3) ? $clog2(DRAIN_CYCLES) : 2;

    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] PRIME_LAST = CNT_W'(2);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    sched_state_t     state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [ROW_W-1:0] row_nx;
    logic             flag_nx;
    logic             swap_ok;
    logic             swap_now;

`ifdef LIFE_SCHED_VBLANK_SYNC_EN
    assign swap_ok = disp_vblank;
`else
    logic unused_vblank;
    assign unused_vblank = disp_vblank;
    assign swap_ok       = 1'b1;
`endif

    // Next state plus the next value of every registered output, so the
    // outputs change on the same edge as the state they describe.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        row_nx   = LAST_ROW;
        flag_nx  = 1'b0;
        swap_now = 1'b0;
        case (state)
            IDLE: begin
                // Parking on the last row clears the line buffer's prime
                // counter and fetch address.
                if (run || step) begin
                    state_nx = PRIME;
                    cnt_nx   = '0;
                    row_nx   = '0;
                end
            end
            PRIME: begin
                row_nx = '0;
                if (cnt == PRIME_LAST) begin
                    state_nx = RUN;
                    row_nx   = ROW_W'(1);
                    flag_nx  = 1'b1;
                end else begin
                    cnt_nx  = cnt + 1'b1;
                    flag_nx = (cnt_nx == PRIME_LAST);
                end
            end
            RUN: begin
                if (calc_row == LAST_ROW) begin
                    state_nx = DRAIN;
                    cnt_nx   = '0;
                end else begin
                    row_nx  = calc_row + 1'b1;
                    flag_nx = 1'b1;
                end
            end
            DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    state_nx = SWAP;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            SWAP: begin
                // While waiting for the swap window the outputs look like DRAIN.
                if (swap_ok) begin
                    swap_now = 1'b1;
                    cnt_nx   = '0;
                    if (run) begin
                        state_nx = PRIME;
                        row_nx   = '0;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            calc_row   <= LAST_ROW;
            calc_flag  <= 1'b0;
            front_bank <= 1'b0;
            busy       <= 1'b0;
            gen_done   <= 1'b0;
            gen_count  <= '0;
            seq_err    <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            calc_row  <= row_nx;
            calc_flag <= flag_nx;
            busy      <= (state_nx != IDLE);
            gen_done  <= swap_now;
            if (swap_now) begin
                front_bank <= ~front_bank;
                gen_count  <= gen_count + 1'b1;
            end
            if (state == RUN && !lb_valid) begin
                seq_err <= 1'b1;
            end
        end
    end

endmodule : life_gen_scheduler

// File: tb/tb_life_gen_scheduler.sv
// tb_life_gen_scheduler
// Self-checking bench for life_gen_scheduler. Expected per-cycle outputs
// are derived from the generation timeline (trigger edge E, PRIME after
// E..E+2, RUN rows 1..719, DRAIN, SWAP, swap visible after edge E+725),
// pushed to a scoreboard queue and popped after each clock edge.
// Define LIFE_SCHED_VBLANK_SYNC_EN for both DUT and bench to exercise the
// vblank-held swap.
module tb_life_gen_scheduler;

    localparam int ROWS   = 720;
    localparam int ROW_W  = 10;
    localparam int DRAIN  = 2;
    localparam int GEN_W  = 16;
    localparam int PERIOD = 3 + (ROWS - 1) + DRAIN + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             run = 1'b0;
    logic             step = 1'b0;
    logic             disp_vblank;
    logic             lb_valid = 1'b1;
    logic [ROW_W-1:0] calc_row;
    logic             calc_flag;
    logic             front_bank;
    logic             busy;
    logic             gen_done;
    logic [GEN_W-1:0] gen_count;
    logic             seq_err;

    life_gen_scheduler #(
        .ROWS(ROWS), .ROW_W(ROW_W), .DRAIN_CYCLES(DRAIN), .GEN_W(GEN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step),
        .disp_vblank(disp_vblank), .lb_valid(lb_valid),
        .calc_row(calc_row), .calc_flag(calc_flag), .front_bank(front_bank),
        .busy(busy), .gen_done(gen_done), .gen_count(gen_count),
        .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int row;
        bit flag;
        bit busy;
        bit gdone;
        bit fb;
        int gc;
        bit serr;
    } exp_t;

    typedef struct {
        string name;
        bit    use_run;
        int    gens;
        int    drop_j;
        int    lbv_j;
        int    stepx_j;
    } test_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   fb_m = 1'b0;
    int   gc_m = 0;
    bit   serr_m = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".calc_row"},   32'(calc_row),   32'(e.row));
        chk({tag, ".calc_flag"},  32'(calc_flag),  32'(e.flag));
        chk({tag, ".busy"},       32'(busy),       32'(e.busy));
        chk({tag, ".gen_done"},   32'(gen_done),   32'(e.gdone));
        chk({tag, ".front_bank"}, 32'(front_bank), 32'(e.fb));
        chk({tag, ".gen_count"},  32'(gen_count),  32'(e.gc));
        chk({tag, ".seq_err"},    32'(seq_err),    32'(e.serr));
    endtask

    function automatic exp_t idle_exp();
        exp_t e;
        e.row = ROWS - 1; e.flag = 1'b0; e.busy = 1'b0; e.gdone = 1'b0;
        e.fb = fb_m; e.gc = gc_m; e.serr = serr_m;
        return e;
    endfunction

    // Expected outputs sampled after edge E+j of a generation sequence.
    function automatic exp_t gen_exp(input int j, input int gens, input bit fb0,
                                     input int gc0, input bit serr);
        exp_t e;
        int m = j % PERIOD;
        int g = j / PERIOD;
        e.fb    = fb0 ^ g[0];
        e.gc    = (gc0 + g) % (1 << GEN_W);
        e.gdone = (j > 0) && (m == 0);
        e.serr  = serr;
        e.busy  = 1'b1;
        if (j == PERIOD * gens) begin
            e.row = ROWS - 1; e.flag = 1'b0; e.busy = 1'b0;
        end else if (m <= 1) begin
            e.row = 0; e.flag = 1'b0;
        end else if (m == 2) begin
            e.row = 0; e.flag = 1'b1;
        end else if (m <= ROWS + 1) begin
            e.row = m - 2; e.flag = 1'b1;
        end else begin
            e.row = ROWS - 1; e.flag = 1'b0;
        end
        return e;
    endfunction

    task automatic run_gen(input test_t t);
        bit fb0   = fb_m;
        int gc0   = gc_m;
        bit serr0 = serr_m;
        run  = t.use_run;
        step = !t.use_run;
        for (int j = 0; j <= PERIOD * t.gens; j++) begin
            sb.push_back(gen_exp(j, t.gens, fb0, gc0,
                                 serr0 || (t.lbv_j >= 0 && j > t.lbv_j)));
            tick();
            compare_out(t.name);
            step = 1'b0;
            if (j == t.drop_j)  run = 1'b0;
            if (j == t.stepx_j) step = 1'b1;
            lb_valid = (j != t.lbv_j);
        end
        run      = 1'b0;
        lb_valid = 1'b1;
        fb_m     = fb0 ^ t.gens[0];
        gc_m     = gc0 + t.gens;
        if (t.lbv_j >= 0) serr_m = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sb.push_back(idle_exp());
            tick();
            compare_out({t.name, ".idle"});
        end
    endtask

    test_t tests[4];

    initial begin
`ifdef LIFE_SCHED_VBLANK_SYNC_EN
        disp_vblank = 1'b1;
`else
        disp_vblank = 1'b0;
`endif
        tests[0] = '{"step1",   1'b0, 1, -1,   -1,  -1};
        tests[1] = '{"run3",    1'b1, 3, 1500, -1,  -1};
        tests[2] = '{"seqerr",  1'b0, 1, -1,   302, -1};
        tests[3] = '{"stepign", 1'b1, 1, 12,   -1,  12};

        // Reset state
        tick();
        tick();
        sb.push_back(idle_exp());
        compare_out("reset");
        #2 rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            sb.push_back(idle_exp());
            tick();
            compare_out("post_reset");
        end

        foreach (tests[i]) run_gen(tests[i]);

`ifdef LIFE_SCHED_VBLANK_SYNC_EN
        // Swap held until vblank; outputs look like DRAIN while waiting.
        begin
            bit fb0 = fb_m;
            int gc0 = gc_m;
            exp_t e;
            disp_vblank = 1'b0;
            step = 1'b1;
            for (int j = 0; j <= 802; j++) begin
                if (j < PERIOD) begin
                    e = gen_exp(j, 2, fb0, gc0, serr_m);
                end else begin
                    e.row = ROWS - 1; e.flag = 1'b0; e.serr = serr_m;
                    e.busy = (j <= 800); e.gdone = (j == 801);
                    e.fb = (j <= 800) ? fb0 : ~fb0;
                    e.gc = (j <= 800) ? gc0 : gc0 + 1;
                end
                sb.push_back(e);
                tick();
                compare_out("vblank");
                step = 1'b0;
                if (j == 800) disp_vblank = 1'b1;
            end
            fb_m = ~fb0;
            gc_m = gc0 + 1;
        end
`endif

        // Make front_bank 1 so the mid-generation reset visibly clears it.
        if (!fb_m) run_gen('{"pre_rst", 1'b0, 1, -1, -1, -1});
        chk("pre_rst.front_bank", 32'(front_bank), 32'd1);
        step = 1'b1;
        for (int j = 0; j <= 402; j++) begin
            tick();
            step = 1'b0;
        end
        chk("rst_mid.row400", 32'(calc_row), 32'd400);
        #2 rst_n = 1'b0;
        #1;
        fb_m = 1'b0; gc_m = 0; serr_m = 1'b0;
        sb.push_back(idle_exp());
        compare_out("rst_mid.async");
        tick();
        #2 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sb.push_back(idle_exp());
            tick();
            compare_out("rst_mid.idle");
        end

        // One more full generation after the reset.
        run_gen('{"post_rst_step", 1'b0, 1, -1, -1, -1});

        chk("sb.drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_life_gen_scheduler

// File: doc/life_gen_scheduler.md
# life_gen_scheduler

Sequences one Game-of-Life generation at a time over the 1280×720 grid. Drives `calc_row`/`calc_flag` into the line buffer and owns the front/back BRAM bank pointer shared by compute and display. Primes row 0 for three cycles, streams rows 1..ROWS-1 one per cycle, drains the next-state writeback pipeline, then swaps banks (optionally only in display vertical blank). Sits between host control (run/step) and line buffer → parallel_next_state → BRAM.

## Interface
Parameters:
- `ROWS`, 720, grid rows per generation
- `ROW_W`, 10, row index width
- `DRAIN_CYCLES`, 2, cycles from last `calc_flag` until writeback to the back bank is complete
- `GEN_W`, 16, generation counter width

Ports:
- `clk` in 1: single clock, all logic on posedge
- `rst_n` in 1: asynchronous, active-low reset
- `run` in 1: level; free-running generations while high
- `step` in 1: one-cycle pulse; one generation when idle
- `disp_vblank` in 1: display in vertical blank (swap window)
- `lb_valid` in 1: line buffer `valid_set`
- `calc_row` out ROW_W: row to line buffer
- `calc_flag` out 1: row is to be computed and written back
- `front_bank` out 1: bank read by compute and display; writes go to `~front_bank`
- `busy` out 1: high in any state except IDLE
- `gen_done` out 1: one-cycle pulse on bank swap
- `gen_count` out GEN_W: completed generations, wraps
- `seq_err` out 1: sticky; `lb_valid` low while RUN

## Operation
- States: IDLE, PRIME, RUN, DRAIN, SWAP.
- IDLE: `calc_row`=ROWS-1 (parks line buffer: clears its prime counter and fetch address), `calc_flag`=0. Exit to PRIME when `run`=1 or `step`=1; `step` while busy is ignored.
- PRIME: `calc_row`=0 for exactly 3 cycles (internal counter 0,1,2); `calc_flag`=0,0,1. Then RUN.
- RUN: `calc_row` = 1..ROWS-1, incrementing each cycle; `calc_flag`=1. If `lb_valid`=0 in any RUN cycle, set `seq_err` (cleared only by reset). After ROWS-1 → DRAIN.
- DRAIN: `calc_row`=ROWS-1, `calc_flag`=0, counts DRAIN_CYCLES, then SWAP.
- SWAP: toggle `front_bank`, pulse `gen_done`, `gen_count`+1 (mod 2^GEN_W), all on the same edge. Next state: PRIME if `run`=1, else IDLE.
- `run` falling mid-generation never aborts; current generation completes and swaps.
- `calc_row` only takes values 0..ROWS-1; `front_bank` never changes outside SWAP.

## Timing
- Reset values: state IDLE, `calc_row`=ROWS-1, `calc_flag`=0, `front_bank`=0, `busy`=0, `gen_done`=0, `gen_count`=0, `seq_err`=0. Reset mid-generation returns to IDLE immediately; the partial back bank is discarded (front unchanged, i.e. 0).
- All outputs registered. Trigger sampled at edge E; PRIME occupies cycles E+1..E+3, RUN E+4..E+722, DRAIN E+723..E+724, SWAP E+725 (defaults, no vblank wait).
- Generation period with `run` held: 3+(ROWS-1)+DRAIN_CYCLES+1 = 725 cycles; next PRIME starts the cycle after SWAP.
- `run` and `step` both high in IDLE: treated as `run`.

## Configuration
- `LIFE_SCHED_VBLANK_SYNC_EN` defined: SWAP is held (outputs as DRAIN) until `disp_vblank`=1; toggle/pulse/increment occur on the first edge with `disp_vblank`=1. Display never sees a mid-frame bank change.
- Undefined: `disp_vblank` ignored; SWAP completes in one cycle.

## Structure
- Shared package `life_pkg`: `ROWS`, `ROW_W`, `COLS`=1280, state enum `sched_state_t` (IDLE, PRIME, RUN, DRAIN, SWAP).
- No sub-module; single FSM with row counter, prime/drain counter, and generation counter.

## Test plan
- Reset, `step` pulse, `lb_valid`=1 → `calc_row` 0,0,0,1..719; `calc_flag` 0,0,1,1×719; `gen_done` at E+725; `front_bank` 0→1; `gen_count`=1; returns IDLE with `calc_row`=719.
- `run` held for 3 generations → `gen_done` at E+725, E+1450, E+2175; `gen_count`=3; `front_bank`=1.
- Macro defined, `disp_vblank` low until E+800 → SWAP held; `gen_done`/toggle at edge where vblank first high; `calc_flag`=0 throughout hold.
- `lb_valid` forced low at RUN row 300 → `seq_err`=1 and stays 1; sequencing continues unchanged.
- `rst_n` low at row 400 → all outputs immediately reset values; `front_bank`=0, `gen_count`=0.
- `step` pulsed during RUN and `run` dropped at row 10 → step ignored; generation completes; exactly one `gen_done`; IDLE.
